matrix_row_load_ctrl: RTL
=========================

Name: matrix_row_load_ctrl

Overview:
- Sequences loading of matrix operands into the 8-byte register bank that feeds the systolic array.
- Accepts a byte stream over a valid/ready handshake and steers each byte into one bank slot with a one-hot select.
- Presents each completed row to the array over a row_valid/row_ready handshake.
- Counts rows per matrix, pulses completion after the last row, and supports abort.

Parameters:
- BANK_DEPTH, 8, number of bank slots (bytes per row); select width equals BANK_DEPTH.
- DATA_WIDTH, 8, width of each matrix element.
- ROWS, 8, rows per matrix; range 1..255.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (asserted at 0).
- start  input  1  one-cycle request to begin loading a matrix.
- abort  input  1  flush; return to IDLE.
- in_valid  input  1  in_data is valid.
- in_data  input  DATA_WIDTH  matrix element.
- in_ready  output  1  controller accepts in_data this cycle.
- bank_enable  output  1  write strobe to register bank.
- bank_select  output  BANK_DEPTH  one-hot slot select to register bank.
- bank_data  output  DATA_WIDTH  write data to register bank.
- row_valid  output  1  bank holds a complete row.
- row_ready  input  1  array consumed the row.
- row_index  output  8  index of the row currently loading or held.
- busy  output  1  state != IDLE.
- matrix_done  output  1  one-cycle pulse after the last row is consumed.

Behaviour:
- Reset: state=IDLE, slot=0, row_cnt=0. All outputs are 0 while reset=0, including bank_select=0 and matrix_done=0.
- States: IDLE, LOAD, HOLD.
- IDLE:
  - in_ready=0 and row_valid=0.
  - start=1 -> LOAD next cycle, with slot=0 and row_cnt=0.
- LOAD:
  - in_ready=1.
  - Acceptance is in_valid & in_ready.
  - On acceptance, in the same cycle (combinational): bank_enable=1, bank_select=1<<slot, bank_data=in_data.
  - Otherwise bank_enable=0, bank_select=0, bank_data=0.
  - slot increments on acceptance.
  - Acceptance at slot==BANK_DEPTH-1 -> HOLD next cycle, with slot=0.
  - in_valid gaps stall without side effects.
- HOLD:
  - row_valid=1 (registered state decode) and in_ready=0; no bank writes.
  - On row_ready=1, if row_cnt==ROWS-1: go to IDLE, pulse matrix_done the next cycle, and clear row_cnt.
  - On row_ready=1 otherwise: row_cnt+1 and go to LOAD.
- Latency:
  - First byte can be accepted 1 cycle after start.
  - row_valid asserts 1 cycle after the 8th accepted byte.
  - A full row needs a minimum of BANK_DEPTH+1 cycles plus the row_ready wait.
- row_index=row_cnt in LOAD and HOLD, and 0 in IDLE.
- matrix_done is a registered pulse, high exactly one cycle while in IDLE.
- Priority: abort > row_ready/acceptance > start.
  - abort=1 in any state -> IDLE next cycle, slot=0, row_cnt=0, no matrix_done.
  - In the abort cycle, bank_enable is forced to 0 and in_ready=0.
- start while busy is ignored.
- start and abort in the same cycle in IDLE: stay in IDLE.
- A new start may be asserted in the cycle matrix_done is high.
- ROWS=1: a single HOLD -> IDLE with done.
- Counters wrap only by explicit clear; slot never exceeds BANK_DEPTH-1.
- Asynchronous reset mid-LOAD or mid-HOLD: immediate return to reset values; the partial bank contents are treated as stale.

Decomposition:
- Shared package / include: state encoding constants (IDLE=2'd0, LOAD=2'd1, HOLD=2'd2) and BANK_DEPTH/DATA_WIDTH defaults.
- Both are shared with the register bank and the data holder.
- Optional sub-module slot_onehot_decoder: slot index -> BANK_DEPTH one-hot, gated by the write strobe.
- Otherwise a single FSM module.

Test Plan:
- Reset then start, then bytes 0x11..0x88 with in_valid continuous:
  - bank_select walks 0x01,0x02,...,0x80 with bank_data matching.
  - row_valid=1 one cycle after 0x88; row_index=0.
- ROWS=2 with both rows fed and row_ready held high:
  - second row loads with row_index=1.
  - matrix_done is a single-cycle pulse after the second row_ready; busy=0 after.
- in_valid toggling 1/0 each cycle: exactly 8 writes, no duplicate selects, bank_enable=0 on gap cycles, row_valid after the 8th write.
- row_ready=0 for 5 cycles in HOLD: row_valid stays 1, in_ready=0, no bank writes; the row releases on the first row_ready=1.
- abort after 3 bytes, then start again: IDLE next cycle, no matrix_done; the restarted load begins at bank_select=0x01, row_index=0.
- reset driven to 0 asynchronously mid-LOAD between clock edges: all outputs go to 0 immediately; start is required to resume.

Source files
------------

// File: rtl/matrix_row_load_ctrl_pkg.sv
// Shared definitions for the matrix row loader, its register bank and data holder.
// Holds the state encoding, the default sizes and the slot-index width helper.
package matrix_row_load_ctrl_pkg;

   localparam int BANK_DEPTH_DEF = 8;
   localparam int DATA_WIDTH_DEF = 8;
   localparam int ROWS_DEF       = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   function automatic int slot_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/matrix_row_load_ctrl_slot_onehot_decoder.sv
// Turns the current slot index into a one-hot bank select.
// The select is qualified by the write strobe, so it reads all zeros when no byte is written.
module matrix_row_load_ctrl_slot_onehot_decoder
   import matrix_row_load_ctrl_pkg::*;
#(
   parameter int BANK_DEPTH = BANK_DEPTH_DEF,
   parameter int SLOT_W     = slot_width(BANK_DEPTH)
) (
   input  logic [SLOT_W-1:0]     slot,
   input  logic                  wr_en,
   output logic [BANK_DEPTH-1:0] onehot
);

   always_comb begin
      onehot = '0;
      for (int i = 0; i < BANK_DEPTH; i++) begin
         onehot[i] = wr_en && (slot == SLOT_W'(i));
      end
   end

endmodule

// File: rtl/matrix_row_load_ctrl.sv
// Loads matrix rows byte by byte into the systolic-array register bank and hands
// each complete row to the array; counts rows and pulses matrix_done after the last.
//
// state | meaning
// IDLE  | waiting for start; no bank writes, no row presented
// LOAD  | accepting bytes into bank slots 0..BANK_DEPTH-1
// HOLD  | complete row presented on row_valid, waiting for row_ready
module matrix_row_load_ctrl
   import matrix_row_load_ctrl_pkg::*;
#(
   parameter int BANK_DEPTH = BANK_DEPTH_DEF,
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int ROWS       = ROWS_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  abort,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  in_ready,
   output logic                  bank_enable,
   output logic [BANK_DEPTH-1:0] bank_select,
   output logic [DATA_WIDTH-1:0] bank_data,
   output logic                  row_valid,
   input  logic                  row_ready,
   output logic [7:0]            row_index,
   output logic                  busy,
   output logic                  matrix_done
);

   localparam int                SLOT_W    = slot_width(BANK_DEPTH);
   localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(BANK_DEPTH - 1);
   localparam logic [7:0]        ROW_LAST  = 8'(ROWS - 1);

   state_t            state_q, state_d;
   logic [SLOT_W-1:0] slot_q, slot_d;
   logic [7:0]        row_cnt_q, row_cnt_d;
   logic              done_q, done_d;
   logic              accept;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         slot_q    <= '0;
         row_cnt_q <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         slot_q    <= slot_d;
         row_cnt_q <= row_cnt_d;
         done_q    <= done_d;
      end
   end

   // abort masks in_ready, which in turn blocks the bank write in the same cycle
   assign in_ready    = (state_q == ST_LOAD) && !abort;
   assign accept      = in_valid && in_ready;
   assign bank_enable = accept;
   assign bank_data   = accept ? in_data : '0;
   assign row_valid   = (state_q == ST_HOLD);
   assign busy        = (state_q != ST_IDLE);
   assign row_index   = (state_q == ST_IDLE) ? 8'd0 : row_cnt_q;
   assign matrix_done = done_q;

   matrix_row_load_ctrl_slot_onehot_decoder #(
      .BANK_DEPTH (BANK_DEPTH),
      .SLOT_W     (SLOT_W)
   ) u_slot_dec (
      .slot   (slot_q),
      .wr_en  (accept),
      .onehot (bank_select)
   );

   always_comb begin
      state_d   = state_q;
      slot_d    = slot_q;
      row_cnt_d = row_cnt_q;
      done_d    = 1'b0;
      if (abort) begin
         state_d   = ST_IDLE;
         slot_d    = '0;
         row_cnt_d = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_d   = ST_LOAD;
                  slot_d    = '0;
                  row_cnt_d = '0;
               end
            end
            ST_LOAD: begin
               if (accept) begin
                  if (slot_q == SLOT_LAST) begin
                     state_d = ST_HOLD;
                     slot_d  = '0;
                  end else begin
                     slot_d = slot_q + SLOT_W'(1);
                  end
               end
            end
            ST_HOLD: begin
               if (row_ready) begin
                  if (row_cnt_q == ROW_LAST) begin
                     state_d   = ST_IDLE;
                     row_cnt_d = '0;
                     done_d    = 1'b1;
                  end else begin
                     state_d   = ST_LOAD;
                     row_cnt_d = row_cnt_q + 8'd1;
                  end
               end
            end
            default: begin
               state_d   = ST_IDLE;
               slot_d    = '0;
               row_cnt_d = '0;
            end
         endcase
      end
   end

endmodule
